// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the PC-select encoding, the queue entry layout and the redirect decode.
package fetch_pkg;

    localparam int XLEN         = 32;
    localparam int PC_SEL_WIDTH = 2;

    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_PC4    = 2'd0;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JAL    = 2'd2;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JALR   = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_redirect(input logic [PC_SEL_WIDTH-1:0] sel);
        return (sel == PC_SEL_BRANCH) || (sel == PC_SEL_JAL) || (sel == PC_SEL_JALR);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the head is read straight from storage so a
// pushed entry becomes visible on the cycle after the write.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  T                           din,
    input  logic                       pop,
    output T                           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T               r_mem [2**AW];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_do_push;
    logic           w_do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push && !clear && !rst) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: variable-latency imem request/response, a fetch
// queue of {pc, instr} feeding decode, and redirect handling with wrong-path drop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [XLEN-1:0]         imem_req_addr,
    input  logic                    imem_rsp_valid,
    input  logic [XLEN-1:0]         imem_rsp_instr,
    input  logic [PC_SEL_WIDTH-1:0] pc_sel,
    input  logic [XLEN-1:0]         br_decode,
    input  logic [XLEN-1:0]         jal_decode,
    input  logic [XLEN-1:0]         jalr_decode,
    output logic                    dec_valid,
    input  logic                    dec_ready,
    output logic [XLEN-1:0]         dec_pc,
    output logic [XLEN-1:0]         dec_instr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0] r_pc;
    logic [OW-1:0]   r_out_cnt;
    logic [OW-1:0]   r_drop_cnt;

    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic            w_rsp;
    logic            w_rsp_drop;
    logic            w_req_fire;
    logic [OW-1:0]   w_out_cnt_nxt;

    fetch_entry_t    w_q_din;
    fetch_entry_t    w_q_head;
    logic            w_q_push;
    logic            w_q_pop;
    logic [CW-1:0]   w_q_count;
    logic            w_q_empty;
    logic            w_q_full;

    logic [XLEN-1:0] w_pc_head;
    logic [OW-1:0]   w_pc_count;
    logic            w_pc_empty;
    logic            w_pc_full;

    assign w_redirect = is_redirect(pc_sel);

    always_comb begin
        w_target = br_decode;
        case (pc_sel)
            PC_SEL_JAL:  w_target = jal_decode;
            PC_SEL_JALR: w_target = jalr_decode;
            default:     w_target = br_decode;
        endcase
    end

    // A response with nothing in flight is stale and is ignored.
    assign w_rsp      = imem_rsp_valid && (r_out_cnt != '0);
    assign w_rsp_drop = w_rsp && (w_redirect || (r_drop_cnt != '0));
    assign w_q_push   = w_rsp && !w_rsp_drop;

    // Reserving a queue slot per in-flight request removes response backpressure.
    assign imem_req_valid = !rst && !w_redirect
                         && ((int'(w_q_count) + int'(r_out_cnt)) < DEPTH)
                         && (int'(r_out_cnt) < MAX_OUTSTANDING);
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    always_comb begin
        w_out_cnt_nxt = r_out_cnt;
        case ({w_req_fire, w_rsp})
            2'b10:   w_out_cnt_nxt = r_out_cnt + OW'(1);
            2'b01:   w_out_cnt_nxt = r_out_cnt - OW'(1);
            default: w_out_cnt_nxt = r_out_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_out_cnt <= w_out_cnt_nxt;
            if (w_redirect) begin
                r_pc       <= w_target;
                r_drop_cnt <= w_out_cnt_nxt;
            end else begin
                if (w_req_fire) r_pc <= r_pc + XLEN'(4);
                if (w_rsp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - OW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (logic [XLEN-1:0])
    ) u_pc_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .push  (w_req_fire),
        .din   (r_pc),
        .pop   (w_rsp),
        .dout  (w_pc_head),
        .count (w_pc_count),
        .empty (w_pc_empty),
        .full  (w_pc_full)
    );

    assign w_q_din.pc    = w_pc_head;
    assign w_q_din.instr = imem_rsp_instr;
    assign w_q_pop       = dec_valid && dec_ready;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .clear (w_redirect),
        .push  (w_q_push),
        .din   (w_q_din),
        .pop   (w_q_pop),
        .dout  (w_q_head),
        .count (w_q_count),
        .empty (w_q_empty),
        .full  (w_q_full)
    );

    assign dec_valid = !w_q_empty;
    assign dec_pc    = w_q_empty ? '0 : w_q_head.pc;
    assign dec_instr = w_q_empty ? '0 : w_q_head.instr;

    a_no_stale_rsp: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (r_out_cnt == '0)));
    a_pc_fifo_sync: assert property (@(posedge clk) disable iff (rst)
        (w_pc_count == r_out_cnt) && !(w_req_fire && w_pc_full) && !(w_rsp && w_pc_empty));
    a_queue_room: assert property (@(posedge clk) disable iff (rst)
        !(w_q_push && w_q_full && !w_q_pop));

endmodule
